// File: rtl/snake_pkg.sv
// Shared types and grid helpers for the snake game-step sequencer.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } seg_t;

  localparam logic [3:0] GRID_MAX = 4'd15;

  typedef logic [2:0] step_state_t;
  localparam step_state_t ST_IDLE   = 3'd0;
  localparam step_state_t ST_CALC   = 3'd1;
  localparam step_state_t ST_SCAN   = 3'd2;
  localparam step_state_t ST_COMMIT = 3'd3;
  localparam step_state_t ST_DEAD   = 3'd4;

  // Opposite directions differ only in bit 0 of the encoding.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  function automatic logic at_border(input seg_t s, input dir_t d);
    case (d)
      DIR_UP:   return s.y == 4'd0;
      DIR_DOWN: return s.y == GRID_MAX;
      DIR_LEFT: return s.x == 4'd0;
      default:  return s.x == GRID_MAX;
    endcase
  endfunction

  function automatic seg_t move_seg(input seg_t s, input dir_t d);
    seg_t m;
    m = s;
    case (d)
      DIR_UP:   m.y = s.y - 4'd1;
      DIR_DOWN: m.y = s.y + 4'd1;
      DIR_LEFT: m.x = s.x - 4'd1;
      default:  m.x = s.x + 4'd1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Circular body buffer: head pointer, one write port, combinational scan
// read and a registered renderer read, with a parallel init pattern.
module snake_body_ram
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 128,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 8,
  parameter int INIT_Y   = 8,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          wr_en,
  input  logic [7:0]    wr_seg,
  input  logic [AW-1:0] scan_k,
  output logic [7:0]    scan_seg,
  input  logic [AW-1:0] rd_off,
  output logic [7:0]    rd_seg
);

  localparam logic [AW-1:0] HP_INIT = AW'(INIT_LEN - 1);

  seg_t          mem_q [MAX_LEN];
  seg_t          mem_d [MAX_LEN];
  logic [AW-1:0] hp_q, hp_d;
  seg_t          rd_seg_q, rd_seg_d;

  // Slot i holds segment (INIT_LEN-1-i) of the initial horizontal snake.
  function automatic seg_t init_seg(input int i);
    seg_t s;
    s = '0;
    if (i < INIT_LEN) begin
      s.x = 4'(INIT_X - (INIT_LEN - 1 - i));
      s.y = 4'(INIT_Y);
    end
    return s;
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    hp_d     = hp_q;
    rd_seg_d = mem_q[hp_q - rd_off];
    for (int i = 0; i < MAX_LEN; i++) mem_d[i] = mem_q[i];
    if (init) begin
      hp_d     = HP_INIT;
      rd_seg_d = '0;
      for (int i = 0; i < MAX_LEN; i++) mem_d[i] = init_seg(i);
    end else if (wr_en) begin
      hp_d        = hp_q + 1'b1;
      mem_d[hp_d] = wr_seg;
    end
  end

  // NOTE: the body store is reset on purpose: its initial contents are the visible starting snake, so it is built from flops, not a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      hp_q     <= HP_INIT;
      rd_seg_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= init_seg(i);
    end else begin
      hp_q     <= hp_d;
      rd_seg_q <= rd_seg_d;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign scan_seg = mem_q[hp_q - scan_k];
  assign rd_seg   = rd_seg_q;

endmodule

// File: rtl/snake_step_ctrl.sv
// Game-step sequencer: computes the next head, checks border and body
// collisions serially, handles food/growth and commits the move.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 128,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 8,
  parameter int INIT_Y   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] dir,
  input  logic [3:0] food_x,
  input  logic [3:0] food_y,
  input  logic       restart,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [7:0] snake_length,
  output logic       busy,
  output logic       step_done,
  output logic       ate,
  output logic       game_over,
  output logic       tick_drop,
  input  logic [7:0] rd_idx,
  output logic [3:0] rd_x,
  output logic [3:0] rd_y,
  output logic       rd_valid
);

  localparam int   AW        = $clog2(MAX_LEN);
  localparam seg_t HEAD_INIT = seg_t'({4'(INIT_X), 4'(INIT_Y)});

  step_state_t   state_q, state_d;
  dir_t          dir_q, dir_d;
  dir_t          last_dir_q, last_dir_d;
  seg_t          head_q, head_d;
  seg_t          nxt_q, nxt_d;
  logic          grow_q, grow_d;
  logic [AW-1:0] scan_n_q, scan_n_d;
  logic [AW-1:0] scan_k_q, scan_k_d;
  logic [8:0]    len_q, len_d;
  logic          step_done_q, step_done_d;
  logic          ate_q, ate_d;
  logic          tick_drop_q, tick_drop_d;
  logic          rd_valid_q, rd_valid_d;

  logic          busy_w;
  logic          wr_en;
  seg_t          food_w;
  logic [7:0]    scan_seg;
  logic [7:0]    rd_seg;
  int            scan_cnt;

  assign busy_w = (state_q == ST_CALC) || (state_q == ST_SCAN) || (state_q == ST_COMMIT);
  assign food_w = {food_x, food_y};

  snake_body_ram #(
    .MAX_LEN (MAX_LEN),
    .INIT_LEN(INIT_LEN),
    .INIT_X  (INIT_X),
    .INIT_Y  (INIT_Y)
  ) u_body (
    .clk     (clk),
    .rst     (rst),
    .init    (restart),
    .wr_en   (wr_en),
    .wr_seg  (nxt_q),
    .scan_k  (scan_k_q),
    .scan_seg(scan_seg),
    .rd_off  (rd_idx[AW-1:0]),
    .rd_seg  (rd_seg)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    last_dir_d  = last_dir_q;
    head_d      = head_q;
    nxt_d       = nxt_q;
    grow_d      = grow_q;
    scan_n_d    = scan_n_q;
    scan_k_d    = scan_k_q;
    len_d       = len_q;
    step_done_d = 1'b0;
    ate_d       = 1'b0;
    tick_drop_d = tick & busy_w;
    rd_valid_d  = ({1'b0, rd_idx} < len_q);
    wr_en       = 1'b0;
    scan_cnt    = 0;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          // A U-turn would run straight into the neck, so it is ignored.
          if (dir_t'(dir) == reverse_dir(last_dir_q) && len_q > 9'd1) dir_d = last_dir_q;
          else                                                        dir_d = dir_t'(dir);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (at_border(head_q, dir_q)) begin
          state_d = ST_DEAD;
        end else begin
          nxt_d    = move_seg(head_q, dir_q);
          grow_d   = (nxt_d == food_w);
          // Without growth the tail cell is vacated by this move, so it is not checked.
          scan_cnt = int'(len_q) - (grow_d ? 1 : 2);
          scan_k_d = AW'(1);
          if (scan_cnt > 0) begin
            scan_n_d = AW'(scan_cnt);
            state_d  = ST_SCAN;
          end else begin
            state_d  = ST_COMMIT;
          end
        end
      end
      ST_SCAN: begin
        if (scan_seg == nxt_q)          state_d  = ST_DEAD;
        else if (scan_k_q == scan_n_q)  state_d  = ST_COMMIT;
        else                            scan_k_d = scan_k_q + 1'b1;
      end
      ST_COMMIT: begin
        wr_en       = 1'b1;
        head_d      = nxt_q;
        last_dir_d  = dir_q;
        if (grow_q && len_q < 9'(MAX_LEN)) len_d = len_q + 9'd1;
        ate_d       = grow_q;
        step_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_DEAD: ;
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d     = ST_IDLE;
      dir_d       = DIR_RIGHT;
      last_dir_d  = DIR_RIGHT;
      head_d      = HEAD_INIT;
      nxt_d       = '0;
      grow_d      = 1'b0;
      scan_n_d    = '0;
      scan_k_d    = '0;
      len_d       = 9'(INIT_LEN);
      step_done_d = 1'b0;
      ate_d       = 1'b0;
      tick_drop_d = 1'b0;
      rd_valid_d  = 1'b0;
      wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      last_dir_q  <= DIR_RIGHT;
      head_q      <= HEAD_INIT;
      nxt_q       <= '0;
      grow_q      <= 1'b0;
      scan_n_q    <= '0;
      scan_k_q    <= '0;
      len_q       <= 9'(INIT_LEN);
      step_done_q <= 1'b0;
      ate_q       <= 1'b0;
      tick_drop_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      last_dir_q  <= last_dir_d;
      head_q      <= head_d;
      nxt_q       <= nxt_d;
      grow_q      <= grow_d;
      scan_n_q    <= scan_n_d;
      scan_k_q    <= scan_k_d;
      len_q       <= len_d;
      step_done_q <= step_done_d;
      ate_q       <= ate_d;
      tick_drop_q <= tick_drop_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign head_x       = head_q.x;
  assign head_y       = head_q.y;
  assign snake_length = len_q[7:0];
  assign busy         = busy_w;
  assign step_done    = step_done_q;
  assign ate          = ate_q;
  assign game_over    = (state_q == ST_DEAD);
  assign tick_drop    = tick_drop_q;
  assign rd_x         = rd_seg[7:4];
  assign rd_y         = rd_seg[3:0];
  assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl: a cycle-by-cycle vector table plus
// hand-written sequences for border death, self-collision, restart and reset.
module tb_snake_step_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, restart;
  logic [1:0] dir;
  logic [3:0] food_x, food_y;
  logic [7:0] rd_idx;
  logic [3:0] head_x, head_y, rd_x, rd_y;
  logic [7:0] snake_length;
  logic       busy, step_done, ate, game_over, tick_drop, rd_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snake_step_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .dir         (dir),
    .food_x      (food_x),
    .food_y      (food_y),
    .restart     (restart),
    .head_x      (head_x),
    .head_y      (head_y),
    .snake_length(snake_length),
    .busy        (busy),
    .step_done   (step_done),
    .ate         (ate),
    .game_over   (game_over),
    .tick_drop   (tick_drop),
    .rd_idx      (rd_idx),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_valid    (rd_valid)
  );

  typedef struct {
    logic       tick;
    logic [1:0] dir;
    logic [3:0] fx, fy;
    logic       rs;
    logic [7:0] idx;
    logic [3:0] hx, hy;
    logic [7:0] len;
    logic       busy, done, ate, go, drop;
    logic [3:0] rx, ry;
    logic       rv;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  function automatic vec_t mk(input logic t, input logic [1:0] d, input logic [3:0] fx, fy,
                              input logic rs, input logic [7:0] idx,
                              input logic [3:0] hx, hy, input logic [7:0] len,
                              input logic b, dn, a, go, dr,
                              input logic [3:0] rx, ry, input logic rv);
    vec_t v;
    v.tick = t;  v.dir = d;   v.fx = fx;  v.fy = fy; v.rs = rs; v.idx = idx;
    v.hx = hx;   v.hy = hy;   v.len = len;
    v.busy = b;  v.done = dn; v.ate = a;  v.go = go; v.drop = dr;
    v.rx = rx;   v.ry = ry;   v.rv = rv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one tick and count edges until step_done; game_over or timeout ends the wait.
  task automatic do_step(input logic [1:0] d, input logic [3:0] fx, fy,
                         input int exp_edges, input logic exp_ate, input string name);
    int n;
    bit seen;
    @(negedge clk);
    tick = 1'b1; dir = d; food_x = fx; food_y = fy;
    n = 0; seen = 0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      tick = 1'b0;
      if (step_done) seen = 1;
      else if (game_over) break;
    end
    check({name, ".latency"}, seen ? n : -1, exp_edges);
    check({name, ".ate"}, ate, exp_ate);
  endtask

  // Issue one tick expected to kill the snake; step_done must never appear.
  task automatic expect_dead(input logic [1:0] d, input int exp_edges, input string name);
    int n;
    bit dead, done_seen;
    @(negedge clk);
    tick = 1'b1; dir = d; food_x = 4'd0; food_y = 4'd0;
    n = 0; dead = 0; done_seen = 0;
    while (!dead && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      tick = 1'b0;
      if (step_done) done_seen = 1;
      if (game_over) dead = 1;
    end
    check({name, ".dead_latency"}, dead ? n : -1, exp_edges);
    check({name, ".no_step_done"}, done_seen, 1'b0);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
  endtask

  task automatic check_init(input string name);
    check({name, ".head_x"}, head_x, 8);
    check({name, ".head_y"}, head_y, 8);
    check({name, ".len"}, snake_length, 3);
    check({name, ".busy"}, busy, 0);
    check({name, ".game_over"}, game_over, 0);
    check({name, ".step_done"}, step_done, 0);
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; restart = 1'b0; dir = RIGHT;
    food_x = 4'd0; food_y = 4'd0; rd_idx = 8'd0;

    //                tick dir   fx fy rs idx  hx  hy len bsy dn ate go drp rx ry rv
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 0,   8,  8, 3,  0,  0, 0,  0, 0,  8, 8, 1));
    vecs.push_back(mk(1, RIGHT,  0, 0, 0, 1,   8,  8, 3,  1,  0, 0,  0, 0,  7, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 2,   8,  8, 3,  1,  0, 0,  0, 0,  6, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 3,   8,  8, 3,  1,  0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 0,   9,  8, 3,  0,  1, 0,  0, 0,  8, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 0,   9,  8, 3,  0,  0, 0,  0, 0,  9, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 1,   9,  8, 3,  0,  0, 0,  0, 0,  8, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 2,   9,  8, 3,  0,  0, 0,  0, 0,  7, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 1, 0,   8,  8, 3,  0,  0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(1, RIGHT,  9, 8, 0, 0,   8,  8, 3,  1,  0, 0,  0, 0,  8, 8, 1));
    vecs.push_back(mk(0, RIGHT,  9, 8, 0, 0,   8,  8, 3,  1,  0, 0,  0, 0,  8, 8, 1));
    vecs.push_back(mk(0, RIGHT,  9, 8, 0, 0,   8,  8, 3,  1,  0, 0,  0, 0,  8, 8, 1));
    vecs.push_back(mk(0, RIGHT,  9, 8, 0, 0,   8,  8, 3,  1,  0, 0,  0, 0,  8, 8, 1));
    vecs.push_back(mk(0, RIGHT,  9, 8, 0, 0,   9,  8, 4,  0,  1, 1,  0, 0,  8, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 3,   9,  8, 4,  0,  0, 0,  0, 0,  6, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 4,   9,  8, 4,  0,  0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(1, LEFT,   0, 0, 0, 0,   9,  8, 4,  1,  0, 0,  0, 0,  9, 8, 1));
    vecs.push_back(mk(1, LEFT,   0, 0, 0, 0,   9,  8, 4,  1,  0, 0,  0, 1,  9, 8, 1));
    vecs.push_back(mk(0, LEFT,   0, 0, 0, 0,   9,  8, 4,  1,  0, 0,  0, 0,  9, 8, 1));
    vecs.push_back(mk(0, LEFT,   0, 0, 0, 0,   9,  8, 4,  1,  0, 0,  0, 0,  9, 8, 1));
    vecs.push_back(mk(0, LEFT,   0, 0, 0, 0,  10,  8, 4,  0,  1, 0,  0, 0,  9, 8, 1));
    vecs.push_back(mk(0, LEFT,   0, 0, 0, 0,  10,  8, 4,  0,  0, 0,  0, 0, 10, 8, 1));
    vecs.push_back(mk(0, RIGHT,  0, 0, 0, 1,  10,  8, 4,  0,  0, 0,  0, 0,  9, 8, 1));

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_init("reset");
    check("reset.rd_valid", rd_valid, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      tick = vecs[i].tick; dir = vecs[i].dir; food_x = vecs[i].fx; food_y = vecs[i].fy;
      restart = vecs[i].rs; rd_idx = vecs[i].idx;
      cycle();
      check($sformatf("v%0d.head_x", i),    head_x,       vecs[i].hx);
      check($sformatf("v%0d.head_y", i),    head_y,       vecs[i].hy);
      check($sformatf("v%0d.len", i),       snake_length, vecs[i].len);
      check($sformatf("v%0d.busy", i),      busy,         vecs[i].busy);
      check($sformatf("v%0d.step_done", i), step_done,    vecs[i].done);
      check($sformatf("v%0d.ate", i),       ate,          vecs[i].ate);
      check($sformatf("v%0d.game_over", i), game_over,    vecs[i].go);
      check($sformatf("v%0d.tick_drop", i), tick_drop,    vecs[i].drop);
      check($sformatf("v%0d.rd_x", i),      rd_x,         vecs[i].rx);
      check($sformatf("v%0d.rd_y", i),      rd_y,         vecs[i].ry);
      check($sformatf("v%0d.rd_valid", i),  rd_valid,     vecs[i].rv);
    end
    tick = 1'b0; restart = 1'b0; rd_idx = 8'd0;

    // Walk to the right border, then step over it.
    do_restart();
    for (int s = 0; s < 7; s++) do_step(RIGHT, 4'd0, 4'd0, 4, 1'b0, $sformatf("walk%0d", s));
    check("walk.head_x", head_x, 15);
    expect_dead(RIGHT, 2, "border");
    check("border.head_x", head_x, 15);
    check("border.head_y", head_y, 8);
    check("border.len", snake_length, 3);
    for (int s = 0; s < 3; s++) begin
      tick = 1'b1; dir = UP;
      cycle();
      tick = 1'b0;
      check($sformatf("dead_tick%0d.tick_drop", s), tick_drop, 0);
      check($sformatf("dead_tick%0d.step_done", s), step_done, 0);
      check($sformatf("dead_tick%0d.game_over", s), game_over, 1);
      check($sformatf("dead_tick%0d.busy", s), busy, 0);
    end
    rd_idx = 8'd1;
    cycle();
    check("dead_rd.rd_x", rd_x, 14);
    check("dead_rd.rd_valid", rd_valid, 1);
    rd_idx = 8'd0;
    do_restart();
    check_init("restart_dead");

    // Grow to 5 and curl back into the body.
    do_step(RIGHT, 4'd9, 4'd8, 5, 1'b1, "grow1");
    do_step(RIGHT, 4'd10, 4'd8, 6, 1'b1, "grow2");
    check("grow2.len", snake_length, 5);
    do_step(DOWN, 4'd0, 4'd0, 6, 1'b0, "curl_down");
    do_step(LEFT, 4'd0, 4'd0, 6, 1'b0, "curl_left");
    check("curl.head_x", head_x, 9);
    check("curl.head_y", head_y, 9);
    expect_dead(UP, 5, "self_hit");
    check("self_hit.head_y", head_y, 9);
    check("self_hit.len", snake_length, 5);

    // Restart in the middle of a scan leaves no pending commit.
    do_restart();
    @(negedge clk);
    tick = 1'b1; dir = RIGHT; food_x = 4'd0; food_y = 4'd0;
    cycle();
    tick = 1'b0;
    cycle();
    check("mid_scan.busy_before", busy, 1);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check_init("mid_scan_restart");
    repeat (4) cycle();
    check("mid_scan.later_head_x", head_x, 8);
    check("mid_scan.later_step_done", step_done, 0);

    // Tick coinciding with restart is discarded.
    tick = 1'b1; restart = 1'b1;
    cycle();
    tick = 1'b0; restart = 1'b0;
    check("tick_restart.busy", busy, 0);
    check("tick_restart.tick_drop", tick_drop, 0);

    // Asynchronous reset mid-step takes effect without a clock edge.
    do_step(RIGHT, 4'd0, 4'd0, 4, 1'b0, "pre_rst");
    check("pre_rst.head_x", head_x, 9);
    @(negedge clk);
    tick = 1'b1; dir = UP;
    @(posedge clk);
    #2 rst = 1'b1; tick = 1'b0;
    #1;
    check_init("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("after_rst.busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
Game-step sequencer for the 16x16 snake game. Owns the snake body storage as a circular buffer. On each game tick it:
- computes the next head position,
- checks the border and, serially, self-collision against the body,
- handles food and growth,
- commits the move.

It sits between the game-tick divider and the VGA/LED renderer, which reads segments through a dedicated read port.

Parameters:
MAX_LEN, 128, body capacity in segments; power of 2, max 256
INIT_LEN, 3, length after reset/restart; 1..MAX_LEN
INIT_X, 8, head x after reset/restart (4-bit)
INIT_Y, 8, head y after reset/restart (4-bit)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle game-step request
dir  in  2  requested direction, sampled on accepted tick: 0=UP(y-1) 1=DOWN(y+1) 2=LEFT(x-1) 3=RIGHT(x+1)
food_x, food_y  in  4 each  current food cell
restart  in  1  synchronous re-init to reset state
head_x, head_y  out  4 each  current head position
snake_length  out  8  current length
busy  out  1  step in progress (state != IDLE/DEAD)
step_done  out  1  one-cycle pulse, move committed
ate  out  1  one-cycle pulse coincident with step_done when food was eaten
game_over  out  1  level, high in DEAD
tick_drop  out  1  one-cycle pulse, tick ignored because busy
rd_idx  in  8  segment index for renderer (0=head)
rd_x, rd_y  out  4 each  segment coords, registered, 1-cycle latency
rd_valid  out  1  registered: rd_idx < snake_length at sample

Behaviour:
- Storage: mem[MAX_LEN] of {x,y}. Segment k lives at mem[(hp - k) mod MAX_LEN].
- Reset/restart values:
  - hp=INIT_LEN-1; segment k=(INIT_X-k mod 16, INIT_Y).
  - last_dir=RIGHT; snake_length=INIT_LEN; state IDLE.
  - All pulses 0, game_over 0, rd_* 0.
  - Restart has priority over every other input in any state, including mid-step.
- FSM: IDLE -> CALC -> SCAN -> COMMIT -> IDLE. Both CALC and SCAN may exit to DEAD.
- IDLE:
  - tick=1 -> CALC, latches dir.
  - If dir is the reverse of last_dir and length>1, last_dir is kept.
- CALC (1 cycle):
  - nx/ny = head moved one cell in the effective direction.
  - Border: moving UP at y=0, DOWN at y=15, LEFT at x=0, or RIGHT at x=15 -> DEAD, no scan.
  - grow = (nx,ny)==(food_x,food_y), sampled this cycle.
  - Scan count N = length-1 if grow, else length-2 (tail vacates). N<=0 skips SCAN.
- SCAN:
  - One segment per cycle, k=1..N.
  - First match -> DEAD the next cycle; remaining segments are not scanned.
- COMMIT (1 cycle):
  - mem[hp+1]<={nx,ny}; hp<=hp+1; last_dir updated.
  - If grow and length<MAX_LEN: length+1. At MAX_LEN the length stays put and the tail moves.
  - ate<=grow.
- Outputs settle the cycle after COMMIT, together with step_done.
- Latency, tick at edge T with no collision: step_done high in cycle T+3+max(N,0), N as computed in CALC.
- tick while busy or in DEAD: tick_drop pulse while busy; no pulse in DEAD. State unaffected.
- tick and restart in the same cycle: restart wins, tick discarded.
- DEAD:
  - game_over=1; head/body/length frozen.
  - Read port stays live.
  - Exit only via rst or restart.
- Read port:
  - rd_x/rd_y = mem[(hp-rd_idx) mod MAX_LEN], registered.
  - Never stalls; it sees the pre-commit value in the COMMIT cycle.
- hp arithmetic is mod MAX_LEN (log2 bits, natural wrap). snake_length is 8-bit and never exceeds MAX_LEN.

Decomposition:
- Package snake_pkg:
  - dir_t enum (UP, DOWN, LEFT, RIGHT);
  - seg_t struct {x[3:0], y[3:0]};
  - GRID_MAX=15;
  - step_state_t enum (IDLE, CALC, SCAN, COMMIT, DEAD).
- Sub-module snake_body_ram: circular buffer with one write port and two read ports (scan, renderer), plus hp handling. Initialisation stays in snake_step_ctrl via sequenced writes on reset/restart, or via a parallel init vector.

Test Plan:
1. Reset, default params, tick with dir=RIGHT, food (0,0) -> step_done at T+4 (N=1); head (9,8); length 3; body (8,8),(7,8); ate=0.
2. Food at (9,8), tick RIGHT -> ate and step_done same cycle; length 4; tail (6,8) retained. Read rd_idx=3 -> rd_x=6, rd_valid=1; rd_idx=4 -> rd_valid=0.
3. Head (15,8), tick RIGHT -> DEAD at T+2; game_over=1; head stays (15,8); further ticks give no step_done and no tick_drop.
4. Self-collision: grow to length 5, then ticks DOWN, LEFT, UP -> third step enters DEAD and game_over rises before any step_done.
5. Length 3 going RIGHT, tick dir=LEFT -> reversal ignored; head x+1. A second tick one cycle later (busy) -> tick_drop pulse, no extra move.
6. restart asserted mid-SCAN and in DEAD -> next cycle head (8,8), length 3, busy=0, game_over=0. rst asserted asynchronously mid-step -> same values immediately.
